// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among N requesters.
// A granted requester keeps the transmitter until it sends a byte flagged last, or until
// it stalls in LOAD for LOCK_TO cycles, at which point the lock is force-released.
module uart_tx_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned LOCK_TO = 1023
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     req_vld_i,
  input  logic [8*N-1:0]   req_data_i,
  input  logic [N-1:0]     req_last_i,
  output logic [N-1:0]     req_rdy_o,
  output logic             tx_vld_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_rdy_i,
  output logic [N-1:0]     grant_o,
  output logic             busy_o,
  output logic             err_timeout_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(LOCK_TO + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StIssue, StSend} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic            seen_low_q, seen_low_d;
  logic            err_q, err_d;

  logic [N-1:0]    pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_found;
  logic [PW:0]     pick_sum;
  logic [7:0]      sel_data;

  assign sel_data = req_data_i[{gidx_q, 3'b000} +: 8];

  // Round-robin pick: first requester set, scanning from ptr+1 upward modulo N.
  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pick_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (pick_sum >= (PW+1)'(N)) pick_sum = pick_sum - (PW+1)'(N);
      if (!pick_found && req_vld_i[pick_sum[PW-1:0]]) begin
        pick_oh[pick_sum[PW-1:0]] = 1'b1;
        pick_idx                  = pick_sum[PW-1:0];
        pick_found                = 1'b1;
      end
    end
  end

  // Saturating lock-timeout increment.
  always_comb begin
    cnt_inc = (cnt_q == CW'(LOCK_TO)) ? cnt_q : cnt_q + CW'(1);
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    last_d     = last_q;
    seen_low_d = seen_low_q;
    err_d      = 1'b0;
    req_rdy_o  = '0;
    tx_vld_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        req_rdy_o = grant_q & req_vld_i & {N{tx_rdy_i}};
        if (|req_rdy_o) begin
          data_d  = sel_data;
          last_d  = req_last_i[gidx_q];
          cnt_d   = '0;
          state_d = StIssue;
        end else if (cnt_inc == CW'(LOCK_TO)) begin
          // Stalled owner: drop the lock so the others are not starved.
          err_d   = 1'b1;
          ptr_d   = gidx_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StIssue: begin
        // tx_rdy is expected high here; gating keeps a stray pulse off a busy transmitter.
        tx_vld_o   = tx_rdy_i;
        seen_low_d = 1'b0;
        if (tx_rdy_i) state_d = StSend;
      end
      StSend: begin
        if (!tx_rdy_i) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          if (last_q) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = StIdle;
          end else begin
            cnt_d   = '0;
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= PW'(N - 1);
      cnt_q      <= '0;
      data_q     <= 8'hFF;
      last_q     <= 1'b0;
      seen_low_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      last_q     <= last_d;
      seen_low_q <= seen_low_d;
      err_q      <= err_d;
    end
  end

  assign tx_data_o     = data_q;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q != StIdle);
  assign err_timeout_o = err_q;

endmodule
